spart_tx: RTL and testbench

//   Transmit half of the SPART. Sits between the processor-side bus
//   (iocs/iorw/ioaddr/databus) and the serial txd pin.

---
 rtl/spart_tx.sv | 136 +++++++++++++
 tb/tb_spart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spart_tx.sv
// SPART transmit half: baud divisor, one-byte buffer and 8N1 shifter driving txd.
// Define SPART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module spart_tx #(
   parameter logic [15:0] DIV_RESET  = 16'd325,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] data_in,
   output logic       tbr,
   output logic       txd
);

   localparam int unsigned    OsW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);

`ifdef SPART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   state_e         state_q, state_d;
   logic [15:0]    div_q, div_d;
   logic [15:0]    baud_q, baud_d;
   logic [OsW-1:0] os_q, os_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     buf_q, buf_d;
   logic [7:0]     shift_q, shift_d;
   logic           tbr_q, tbr_d;
`ifdef SPART_TX_PARITY_EN
   logic           parity_q, parity_d;
`endif

   logic wr, wr_data, en16, bit_tick, xfer;

   assign wr       = iocs && !iorw;
   assign wr_data  = wr && (ioaddr == 2'b00) && tbr_q;
   assign en16     = (baud_q == 16'd0);
   assign bit_tick = en16 && (os_q == OsLast);
   // Buffer moves into the shifter when idle, or on the edge the stop bit ends.
   assign xfer     = !tbr_q && ((state_q == StIdle) || ((state_q == StStop) && bit_tick));

   always_comb begin
      div_d = div_q;
      if (wr && (ioaddr == 2'b10)) div_d[7:0]  = data_in;
      if (wr && (ioaddr == 2'b11)) div_d[15:8] = data_in;

      // Reload reads div_q, so a divisor written on this edge waits for the next reload.
      if (xfer || en16) baud_d = div_q;
      else              baud_d = baud_q - 16'd1;

      if (state_q == StIdle) os_d = '0;
      else if (en16)         os_d = (os_q == OsLast) ? '0 : os_q + OsW'(1);
      else                   os_d = os_q;

      buf_d = wr_data ? data_in : buf_q;

      tbr_d = tbr_q;
      if (wr_data)   tbr_d = 1'b0;
      else if (xfer) tbr_d = 1'b1;

      shift_d = shift_q;
      bit_d   = bit_q;
      if (xfer) begin
         shift_d = buf_q;
      end else if ((state_q == StData) && bit_tick) begin
         shift_d = {1'b0, shift_q[7:1]};
         bit_d   = bit_q + 3'd1;
      end
`ifdef SPART_TX_PARITY_EN
      parity_d = xfer ? ^buf_q : parity_q;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         div_q    <= DIV_RESET;
         baud_q   <= DIV_RESET;
         os_q     <= '0;
         bit_q    <= 3'd0;
         buf_q    <= 8'd0;
         shift_q  <= 8'd0;
         tbr_q    <= 1'b1;
`ifdef SPART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         baud_q   <= baud_d;
         os_q     <= os_d;
         bit_q    <= bit_d;
         buf_q    <= buf_d;
         shift_q  <= shift_d;
         tbr_q    <= tbr_d;
`ifdef SPART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (xfer) state_d = StStart;
         StStart: if (bit_tick) state_d = StData;
`ifdef SPART_TX_PARITY_EN
         StData:   if (bit_tick && (bit_q == 3'd7)) state_d = StParity;
         StParity: if (bit_tick) state_d = StStop;
`else
         StData:  if (bit_tick && (bit_q == 3'd7)) state_d = StStop;
`endif
         StStop:  if (bit_tick) state_d = xfer ? StStart : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tbr = tbr_q;
      txd = 1'b1;
      case (state_q)
         StStart:  txd = 1'b0;
         StData:   txd = shift_q[0];
`ifdef SPART_TX_PARITY_EN
         StParity: txd = parity_q;
`endif
         default:  txd = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: reset, bus decode, framing, back-to-back and async reset.
// Build with SPART_TX_PARITY_EN defined to exercise the parity bit.
module tb_spart_tx;

   logic       clk;
   logic       rst;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] data_in;
   logic       tbr;
   logic       txd;

   int n_checks = 0;
   int n_fail   = 0;
   int bit_clks = 32;

`ifdef SPART_TX_PARITY_EN
   localparam int NBits = 11;
`else
   localparam int NBits = 10;
`endif

   spart_tx dut (
      .clk     (clk),
      .rst     (rst),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .data_in (data_in),
      .tbr     (tbr),
      .txd     (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the access is captured on the following posedge.
   task automatic bus(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
      iocs    = cs;
      iorw    = rw;
      ioaddr  = a;
      data_in = d;
      @(negedge clk);
      iocs    = 1'b0;
      iorw    = 1'b0;
      ioaddr  = 2'b00;
      data_in = 8'h00;
   endtask

   task automatic set_div(input logic [15:0] v);
      bus(1'b1, 1'b0, 2'b10, v[7:0]);
      bus(1'b1, 1'b0, 2'b11, v[15:8]);
   endtask

   // Starts 'elapsed' negedges after the first start-bit sample; checks every cycle.
   task automatic check_frame(input logic [7:0] d, input int elapsed);
      logic [10:0] fr;
`ifdef SPART_TX_PARITY_EN
      fr = {1'b1, ^d, d, 1'b0};
`else
      fr = {1'b0, 1'b1, d, 1'b0};
`endif
      for (int t = elapsed; t < NBits * bit_clks; t++) begin
         chk($sformatf("frame %h bit %0d cyc %0d", d, t / bit_clks, t % bit_clks),
             txd, fr[t / bit_clks]);
         @(negedge clk);
      end
   endtask

   initial begin
      rst     = 1'b0;
      iocs    = 1'b0;
      iorw    = 1'b0;
      ioaddr  = 2'b00;
      data_in = 8'h00;

      // 1: reset state
      #12;
      chk("reset txd", txd, 1'b1);
      chk("reset tbr", tbr, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post-reset txd", txd, 1'b1);
      chk("post-reset tbr", tbr, 1'b1);

      // 2: div=1, send A5 -> 0,1,0,1,0,0,1,0,1,1 at 32 clks per bit
      set_div(16'h0001);
      bit_clks = 32;
      bus(1'b1, 1'b0, 2'b00, 8'hA5);
      chk("t2 tbr low after write", tbr, 1'b0);
      @(negedge clk);
      chk("t2 tbr back high", tbr, 1'b1);
      check_frame(8'hA5, 0);
      chk("t2 idle txd", txd, 1'b1);
      chk("t2 idle tbr", tbr, 1'b1);

      // 4: ignored accesses leave txd, tbr and the divisor alone
      bus(1'b0, 1'b0, 2'b00, 8'hFF);
      chk("t4 cs0 data tbr", tbr, 1'b1);
      bus(1'b0, 1'b0, 2'b10, 8'hFF);
      bus(1'b0, 1'b0, 2'b11, 8'hFF);
      bus(1'b1, 1'b1, 2'b00, 8'hFF);
      chk("t4 read data tbr", tbr, 1'b1);
      bus(1'b1, 1'b1, 2'b10, 8'hFF);
      bus(1'b1, 1'b1, 2'b11, 8'hFF);
      bus(1'b1, 1'b0, 2'b01, 8'hFF);
      chk("t4 status write tbr", tbr, 1'b1);
      repeat (4) begin
         @(negedge clk);
         chk("t4 txd idle", txd, 1'b1);
         chk("t4 tbr idle", tbr, 1'b1);
      end

      // 3: 55 then 0F back-to-back; 33 written while full is dropped
      bus(1'b1, 1'b0, 2'b00, 8'h55);
      chk("t3 tbr low 55", tbr, 1'b0);
      @(negedge clk);
      chk("t3 tbr high at start", tbr, 1'b1);
      bus(1'b1, 1'b0, 2'b00, 8'h0F);
      chk("t3 tbr low 0F", tbr, 1'b0);
      bus(1'b1, 1'b0, 2'b00, 8'h33);
      chk("t3 tbr still low", tbr, 1'b0);
      check_frame(8'h55, 2);
      chk("t3 tbr after 2nd xfer", tbr, 1'b1);
      check_frame(8'h0F, 0);
      for (int i = 0; i < 2 * 32; i++) begin
         chk("t3 no third frame", txd, 1'b1);
         @(negedge clk);
      end
      chk("t3 final tbr", tbr, 1'b1);

      // 5: async reset during data bit 3 of A5, then 3C at the reset divisor
      bus(1'b1, 1'b0, 2'b00, 8'hA5);
      @(negedge clk);
      bus(1'b1, 1'b0, 2'b00, 8'hFF);
      repeat (143) @(negedge clk);
      chk("t5 txd data bit 3", txd, 1'b0);
      chk("t5 tbr full", tbr, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("t5 async txd", txd, 1'b1);
      chk("t5 async tbr", tbr, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t5 idle after reset", txd, 1'b1);
      end
      bit_clks = 16 * 326;
      bus(1'b1, 1'b0, 2'b00, 8'h3C);
      chk("t5 tbr low 3C", tbr, 1'b0);
      @(negedge clk);
      check_frame(8'h3C, 0);
      chk("t5 idle txd", txd, 1'b1);

`ifdef SPART_TX_PARITY_EN
      // 6: parity bit of A5 is 0, of 07 is 1
      set_div(16'h0001);
      bit_clks = 32;
      bus(1'b1, 1'b0, 2'b00, 8'hA5);
      @(negedge clk);
      repeat (9 * 32 + 16) @(negedge clk);
      chk("t6 parity A5", txd, 1'b0);
      repeat (2 * 32) @(negedge clk);
      bus(1'b1, 1'b0, 2'b00, 8'h07);
      @(negedge clk);
      repeat (9 * 32 + 16) @(negedge clk);
      chk("t6 parity 07", txd, 1'b1);
      repeat (32) @(negedge clk);
      chk("t6 stop 07", txd, 1'b1);
      repeat (2 * 32) @(negedge clk);
      bus(1'b1, 1'b0, 2'b00, 8'h07);
      @(negedge clk);
      check_frame(8'h07, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
